serial_add_host: RTL and testbench
==================================

SERIAL_ADD_HOST -- requirements
Module: serial_add_host

Interface
REQ-001 The block SHALL take parameter WIDTH, default 4, as the operand width in bits, with WIDTH >= 2.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state SHALL update on the rising edge.
REQ-003 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-004 The block SHALL have port start, input, 1 bit: request to add op_a and op_b; sampled only in IDLE.
REQ-005 The block SHALL have port op_a, input, WIDTH bits: first operand, unsigned.
REQ-006 The block SHALL have port op_b, input, WIDTH bits: second operand, unsigned.
REQ-007 The block SHALL have port a, output, 1 bit: serial operand A to the serial adder, LSB first.
REQ-008 The block SHALL have port b, output, 1 bit: serial operand B to the serial adder, LSB first.
REQ-009 The block SHALL have port adder_reset, output, 1 bit: synchronous clear of the serial adder's carry flop.
REQ-010 The block SHALL have port s, input, 1 bit: serial sum from the adder, equal to a^b^carry in the same cycle.
REQ-011 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.
REQ-012 The block SHALL have port done, output, 1 bit: one-cycle pulse when sum is updated.
REQ-013 The block SHALL have port sum, output, WIDTH+1 bits: last completed result, including the carry-out as its MSB.

Function
REQ-014 The block SHALL implement an FSM with states IDLE, CLEAR, SHIFT and DONE.
REQ-015 IDLE with start=1 SHALL latch op_a/op_b into shift registers and go to CLEAR; start=0 SHALL stay in IDLE.
REQ-016 CLEAR SHALL last exactly 1 cycle, with adder_reset=1 and a=b=0, then go to SHIFT with the bit counter at 0.
REQ-017 SHIFT SHALL last exactly WIDTH+1 cycles; in cycle k (k=0..WIDTH-1), a=op_a[k] and b=op_b[k]; in cycle WIDTH, a=b=0 so that s carries the carry-out.
REQ-018 In each SHIFT cycle the block SHALL capture s into a right-shifting result register (s enters at bit WIDTH), so that after WIDTH+1 captures bit k holds sum bit k.
REQ-019 After the last SHIFT cycle the block SHALL go to DONE; DONE SHALL load sum from the result register, assert done for exactly 1 cycle, and return to IDLE.
REQ-020 Latency SHALL be fixed: with start accepted on edge 0, done SHALL be high in the cycle after edge WIDTH+2 (WIDTH+3 cycles total); busy SHALL be high for exactly those WIDTH+3 cycles.
REQ-021 start asserted while busy=1 SHALL be ignored, and op_a/op_b changes during busy SHALL have no effect on the running operation.
REQ-022 start held high continuously SHALL begin a new operation in the cycle after DONE (back-to-back operation allowed, with 1 IDLE cycle between).
REQ-023 Outside CLEAR and SHIFT, a=b=0 SHALL hold; adder_reset SHALL be high only in CLEAR or while reset=1.
REQ-024 The result SHALL equal (op_a + op_b) mod 2^(WIDTH+1) exactly, with no overflow lost.
REQ-025 sum SHALL hold its value from one DONE until the next DONE or reset.

Reset
REQ-026 While reset=1 the block SHALL go to IDLE and set a=0, b=0, busy=0, done=0, sum=0, and counter and shift registers to 0, with adder_reset=1.
REQ-027 reset asserted in any state (including mid-SHIFT) SHALL abort the operation on that edge with no done pulse; sum SHALL be 0 afterwards.
REQ-028 The first start after reset release SHALL be accepted normally.

Verification (WIDTH=4; the bench models the adder as s=a^b^c, with c registered and cleared by adder_reset)
REQ-029 op_a=0, op_b=1, start -> done after 7 cycles, sum=5'b00001; the a/b streams are 0000,1000 LSB first, plus the trailing 0.
REQ-030 op_a=4'b0101, op_b=4'b1010 -> sum=5'b01111.
REQ-031 op_a=4'b1000, op_b=4'b0010 -> sum=5'b01010; then op_a=op_b=4'b1111 -> sum=5'b11110 (carry-out captured).
REQ-032 start pulsed again 2 cycles into an operation, with new operands -> ignored; the original result is reported and only one done pulse occurs.
REQ-033 reset=1 for 1 cycle mid-SHIFT -> busy=0 and sum=0 next cycle, no done pulse; a following start with 3+4 -> sum=5'b00111.
REQ-034 start held high for 20 cycles with fixed operands -> done pulses every WIDTH+4=8 cycles, and sum stays identical each time.

Source files
------------

// File: rtl/serial_add_host_if.sv
// Bundle between the host controller and its environment: the operand/result
// handshake plus the serial adder link (a, b, adder_reset out; s back in).
interface serial_add_host_if #(
  parameter int unsigned WIDTH = 4
) ();
  logic             start;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic             a;
  logic             b;
  logic             adder_reset;
  logic             s;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   sum;

  // The requester side also owns the serial adder, so it drives s.
  modport master (
    output start, op_a, op_b, s,
    input  a, b, adder_reset, busy, done, sum
  );

  modport slave (
    input  start, op_a, op_b, s,
    output a, b, adder_reset, busy, done, sum
  );
endinterface

// File: rtl/serial_add_host.sv
// Host controller for a bit-serial adder: streams two WIDTH-bit operands LSB
// first, collects the serial sum plus carry-out, reports it with a done pulse.
module serial_add_host #(
  parameter int unsigned WIDTH = 4
) (
  input logic              clk,
  input logic              reset,
  serial_add_host_if.slave bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH);

  typedef enum logic [1:0] {StIdle, StClear, StShift, StDone} state_e;

  state_e           state_q;
  logic [CntW-1:0]  cnt_q;
  logic [WIDTH-1:0] sa_q;
  logic [WIDTH-1:0] sb_q;
  logic [WIDTH:0]   res_q;
  logic [WIDTH:0]   sum_q;
  logic             a_q;
  logic             b_q;
  logic             clr_q;
  logic             busy_q;
  logic             done_q;

  // Sequencer: all outputs are registered so each reflects the state it belongs to.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      sa_q    <= '0;
      sb_q    <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      a_q     <= 1'b0;
      b_q     <= 1'b0;
      clr_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          a_q <= 1'b0;
          b_q <= 1'b0;
          if (bus.start) begin
            sa_q    <= bus.op_a;
            sb_q    <= bus.op_b;
            clr_q   <= 1'b1;
            busy_q  <= 1'b1;
            state_q <= StClear;
          end
        end
        StClear: begin
          // Present bit 0 for the first shift cycle.
          clr_q   <= 1'b0;
          cnt_q   <= '0;
          res_q   <= '0;
          a_q     <= sa_q[0];
          b_q     <= sb_q[0];
          sa_q    <= sa_q >> 1;
          sb_q    <= sb_q >> 1;
          state_q <= StShift;
        end
        StShift: begin
          // Zeros shift in behind the operands, so cycle WIDTH sees a=b=0
          // and s is the carry-out.
          res_q <= {bus.s, res_q[WIDTH:1]};
          a_q   <= sa_q[0];
          b_q   <= sb_q[0];
          sa_q  <= sa_q >> 1;
          sb_q  <= sb_q >> 1;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == LastCnt) begin
            // Final capture goes straight to sum so it is valid with done.
            sum_q   <= {bus.s, res_q[WIDTH:1]};
            done_q  <= 1'b1;
            a_q     <= 1'b0;
            b_q     <= 1'b0;
            state_q <= StDone;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign bus.a           = a_q;
  assign bus.b           = b_q;
  // Reset input is ORed in so the adder carry clears on the same edge as we do.
  assign bus.adder_reset = clr_q | reset;
  assign bus.busy        = busy_q;
  assign bus.done        = done_q;
  assign bus.sum         = sum_q;

endmodule

// File: tb/tb_serial_add_host.sv
// Bench for serial_add_host with a behavioural serial adder and arithmetic reference.
module tb_serial_add_host;

  localparam int W = 4;

  logic clk;
  logic reset;
  int   checks;
  int   errors;

  serial_add_host_if #(.WIDTH(W)) bus ();

  serial_add_host #(.WIDTH(W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Serial adder: carry flop cleared by adder_reset, sum combinational.
  logic c_q;
  always @(posedge clk) begin
    if (bus.adder_reset) c_q <= 1'b0;
    else c_q <= (bus.a & bus.b) | (bus.a & c_q) | (bus.b & c_q);
  end
  assign bus.s = bus.a ^ bus.b ^ c_q;

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W:0]   s;
  } vec_t;

  vec_t vecs[7];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One full operation from IDLE: checks clear cycle, streams, latency, busy, sum.
  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                       input logic [W:0] exp, input string name);
    logic [W:0] sa;
    logic [W:0] sb;
    logic [W:0] got;
    int         done_at;
    int         busy_n;
    int         dones;
    sa = '0;
    sb = '0;
    got = '0;
    done_at = -1;
    busy_n = 0;
    dones = 0;
    bus.op_a  = oa;
    bus.op_b  = ob;
    bus.start = 1'b1;
    for (int cyc = 1; cyc <= W + 4; cyc++) begin
      tick();
      if (cyc == 1) begin
        bus.start = 1'b0;
        bus.op_a  = W'($urandom);
        bus.op_b  = W'($urandom);
        check({name, "_clear"}, 32'({bus.adder_reset, bus.a, bus.b}), 32'b100);
      end
      if (cyc >= 2 && cyc <= W + 2) begin
        sa[cyc-2] = bus.a;
        sb[cyc-2] = bus.b;
      end
      if (bus.busy) busy_n++;
      if (bus.done) begin
        dones++;
        if (done_at < 0) begin
          done_at = cyc;
          got = bus.sum;
        end
      end
    end
    check({name, "_latency"}, 32'(done_at), 32'(W + 3));
    check({name, "_dones"}, 32'(dones), 32'd1);
    check({name, "_busy"}, 32'(busy_n), 32'(W + 3));
    check({name, "_astream"}, 32'(sa), 32'({1'b0, oa}));
    check({name, "_bstream"}, 32'(sb), 32'({1'b0, ob}));
    check({name, "_sum"}, 32'(got), 32'(exp));
  endtask

  initial begin
    int         dq[$];
    int         n;
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    checks = 0;
    errors = 0;

    vecs[0] = '{a: 4'd0,  b: 4'd1,  s: 5'b00001};
    vecs[1] = '{a: 4'b0101, b: 4'b1010, s: 5'b01111};
    vecs[2] = '{a: 4'b1000, b: 4'b0010, s: 5'b01010};
    vecs[3] = '{a: 4'b1111, b: 4'b1111, s: 5'b11110};
    vecs[4] = '{a: 4'd3,  b: 4'd4,  s: 5'b00111};
    vecs[5] = '{a: 4'd15, b: 4'd1,  s: 5'b10000};
    vecs[6] = '{a: 4'd0,  b: 4'd0,  s: 5'b00000};

    // Reset state.
    reset = 1'b1;
    bus.start = 1'b0;
    bus.op_a = '0;
    bus.op_b = '0;
    tick();
    tick();
    check("rst_outs", 32'({bus.busy, bus.done, bus.a, bus.b}), 32'd0);
    check("rst_sum", 32'(bus.sum), 32'd0);
    check("rst_adder_reset", 32'(bus.adder_reset), 32'd1);
    reset = 1'b0;
    tick();
    check("idle_adder_reset", 32'(bus.adder_reset), 32'd0);

    // Table vectors.
    for (int i = 0; i < 7; i++) begin
      do_op(vecs[i].a, vecs[i].b, vecs[i].s, $sformatf("vec%0d", i));
    end

    // sum holds while idle with operands changing.
    for (int i = 0; i < 3; i++) begin
      bus.op_a = W'($urandom);
      tick();
    end
    check("hold_sum_idle", 32'(bus.sum), 32'(vecs[6].s));

    // Randomized against arithmetic model.
    for (int i = 0; i < 20; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      do_op(ra, rb, (W + 1)'(ra) + (W + 1)'(rb), $sformatf("rnd%0d", i));
    end

    // start and operand changes during busy are ignored.
    bus.op_a = 4'b1000;
    bus.op_b = 4'b0010;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    bus.start = 1'b1;
    bus.op_a = 4'b1111;
    bus.op_b = 4'b1111;
    tick();
    bus.start = 1'b0;
    n = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (bus.done) begin
        n++;
        check("busy_start_sum", 32'(bus.sum), 32'b01010);
      end
    end
    check("busy_start_dones", 32'(n), 32'd1);

    // Reset mid-SHIFT aborts without done.
    bus.op_a = 4'd5;
    bus.op_b = 4'd6;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_sum", 32'(bus.sum), 32'd0);
    check("abort_ab", 32'({bus.a, bus.b, bus.done}), 32'd0);
    n = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (bus.done) n++;
    end
    check("abort_no_done", 32'(n), 32'd0);
    do_op(4'd3, 4'd4, 5'b00111, "after_abort");

    // start held high: back-to-back operations every W+4 cycles.
    bus.op_a = 4'd9;
    bus.op_b = 4'd9;
    bus.start = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (bus.done) begin
        dq.push_back(i);
        check("b2b_sum", 32'(bus.sum), 32'd18);
      end
      if (i == 19) bus.start = 1'b0;
    end
    check("b2b_pulses", 32'(dq.size()), 32'd3);
    for (int i = 1; i < dq.size(); i++) begin
      check("b2b_interval", 32'(dq[i] - dq[i-1]), 32'(W + 4));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
